ext_irq_ctrl: RTL and testbench
===============================

Name: ext_irq_ctrl

Overview:
- Sits between the SoC's 31 external interrupt lines (i_ext) and the CPU core's interrupt input.
- Synchronises each line and detects edges or levels per line, then latches requests into a pending register.
- Applies a per-line enable mask and selects the highest-priority request with a fixed priority encoder.
- Presents one request at a time to the core through an irq/ack/eoi handshake.

Parameters:
- N_IRQ, 31, number of external interrupt lines.
- ID_W, 5, width of the interrupt id; must satisfy 2^ID_W >= N_IRQ.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2).

Ports:
- Clk  in  1  system clock; all state is updated on the rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- i_ext  in  N_IRQ  raw asynchronous external interrupt lines, active-high.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  2  register select: 0 = ENABLE, 1 = MODE (1 = edge, 0 = level), 2 = PENDING, 3 = STATUS (read-only).
- cfg_wdata  in  N_IRQ  write data.
- cfg_rdata  out  N_IRQ  combinational read of the register selected by cfg_addr.
- irq  out  1  interrupt request to the core.
- irq_id  out  ID_W  index of the line being requested or serviced.
- irq_ack  in  1  one-cycle pulse from the core: request accepted.
- irq_eoi  in  1  one-cycle pulse from the core: service routine finished.

Behaviour:
- Reset (asynchronous): sync chains, previous-sample register, ENABLE, MODE and PENDING all clear to 0. FSM goes to IDLE; irq = 0, irq_id = 0.
- Synchroniser: a SYNC_STAGES flop chain per line produces s[i].
- Input timing: a line must be held high across at least one rising Clk edge to be seen. Narrower pulses may be lost; this is accepted.
- Edge mode (MODE[i] = 1): s[i] & ~prev[i] sets PENDING[i]. It stays set until cleared by ack or by software.
- Level mode (MODE[i] = 0): PENDING[i] follows s[i] each cycle and is never latched.
- Latency: an edge on i_ext reaches PENDING SYNC_STAGES+1 cycles later. irq rises in the next cycle, so irq is high SYNC_STAGES+2 cycles after the sampled edge.
- Candidate vector: req = PENDING & ENABLE. Priority is fixed, lowest index wins.
- FSM states:
  - IDLE: if req != 0, latch irq_id = lowest set index and go to REQ.
  - REQ: irq = 1 and irq_id is frozen, even if a higher-priority line arrives. On irq_ack: clear PENDING[irq_id] if that line is in edge mode, go to SERVICE.
  - SERVICE: irq = 0, irq_id held. On irq_eoi go to IDLE. No nesting.
- Line disappears while in REQ: if req[irq_id] drops because the enable was cleared or a level line deasserted, return to IDLE with irq = 0 the next cycle. The request is withdrawn.
- irq_ack outside REQ, or irq_eoi outside SERVICE: ignored.
- irq_ack and irq_eoi in the same cycle: only irq_ack is acted upon.
- Software writes:
  - ENABLE and MODE: written on cfg_we.
  - PENDING: write-1-to-clear, edge-mode bits only.
  - STATUS: read returns a one-hot of irq_id when not IDLE, otherwise 0.
- Write-clear vs new edge on the same bit in the same cycle: the new edge wins, so the bit stays set.
- Ack-clear vs new edge on the same line in the same cycle: the new edge wins, so the bit stays pending.
- MODE change from edge to level: the pending bit immediately tracks s[i].
- Reset asserted mid-handshake: everything returns to reset values immediately; irq drops asynchronously.

Decomposition:
- Shared package irq_pkg:
  - FSM state encoding: IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2.
  - Register address constants: ADDR_ENABLE, ADDR_MODE, ADDR_PENDING, ADDR_STATUS.
  - Default N_IRQ and ID_W.
- One sub-module, irq_prio_enc: parameterised, purely combinational, N_IRQ-bit vector in, ID_W-bit index plus valid out.
- The synchroniser is a generate loop, not a separate module.

Test Plan:
- Reset: hold Rst = 1, toggle i_ext = all ones -> irq = 0, irq_id = 0, all register reads return 0; release Rst, ENABLE still 0, so irq stays 0.
- Basic edge: ENABLE = 0x1FE, MODE = 0x1FE; pulse i_ext[2] high for 3 cycles -> irq = 1 with irq_id = 2 exactly 4 cycles after the edge is sampled; irq_ack -> PENDING[2] = 0, irq = 0; irq_eoi -> IDLE.
- Priority: set i_ext[8] and i_ext[2] in the same cycle, both edge-enabled -> id 2 served first; after eoi, irq re-asserts with irq_id = 8.
- Level mode: MODE[3] = 0, ENABLE[3] = 1; hold i_ext[3] = 1 -> irq_id = 3; drop i_ext[3] while in REQ -> irq falls next cycle, FSM back in IDLE.
- Narrow pulse: 4 ns pulse on i_ext[1] that straddles no Clk edge -> no pending bit; pulse that straddles an edge -> PENDING[1] set.
- Write-clear race: while PENDING[5] = 1, write 1 to PENDING bit 5 in the same cycle a new edge arrives on line 5 -> PENDING[5] remains 1.
- Reset mid-handshake: pulse Rst while in REQ -> irq drops without waiting for Clk; registers read back 0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the external interrupt controller.
package irq_pkg;

  localparam int N_IRQ_DEF = 31;
  localparam int ID_W_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc #(
  parameter int N_IRQ = 31,
  parameter int ID_W  = 5
) (
  input  logic [N_IRQ-1:0] req,
  output logic [ID_W-1:0]  idx,
  output logic             valid
);

  // Scan high-to-low so the last (lowest) hit overrides.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: sync, edge/level detect, pending, mask,
// priority select and irq/ack/eoi handshake towards the core.
module ext_irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_IRQ       = N_IRQ_DEF,
  parameter int ID_W        = ID_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_IRQ-1:0] i_ext,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [N_IRQ-1:0] cfg_wdata,
  output logic [N_IRQ-1:0] cfg_rdata,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic             irq_eoi
);

  logic [N_IRQ-1:0] s, prev, enable, mode, pending, pending_d;
  logic [N_IRQ-1:0] req, edge_det, ack_clr, w1c, status;
  logic [ID_W-1:0]  win_idx;
  logic             win_vld;
  irq_state_e       state;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain;
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) chain <= '0;
      else     chain <= {chain[SYNC_STAGES-2:0], i_ext[i]};
    end
    assign s[i] = chain[SYNC_STAGES-1];
  end

  assign edge_det = s & ~prev;
  assign req      = pending & enable;
  assign ack_clr  = (state == REQ && irq_ack) ? (N_IRQ'(1) << irq_id) : '0;
  assign w1c      = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata : '0;
  // Edge bits: clears applied first so a coincident new edge survives.
  // Level bits simply mirror the synchronised line.
  assign pending_d = (mode & ((pending & ~(ack_clr | w1c)) | edge_det))
                   | (~mode & s);
  assign status    = (state != IDLE) ? (N_IRQ'(1) << irq_id) : '0;

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ENABLE:  cfg_rdata = enable;
      ADDR_MODE:    cfg_rdata = mode;
      ADDR_PENDING: cfg_rdata = pending;
      default:      cfg_rdata = status;
    endcase
  end

  irq_prio_enc #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_prio (
    .req   (req),
    .idx   (win_idx),
    .valid (win_vld)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      prev    <= '0;
      enable  <= '0;
      mode    <= '0;
      pending <= '0;
    end else begin
      prev    <= s;
      pending <= pending_d;
      if (cfg_we && cfg_addr == ADDR_ENABLE) enable <= cfg_wdata;
      if (cfg_we && cfg_addr == ADDR_MODE)   mode   <= cfg_wdata;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          irq_id <= win_idx;
          irq    <= 1'b1;
          state  <= REQ;
        end
        // Ack takes precedence; otherwise a vanished request is withdrawn.
        REQ: if (irq_ack) begin
          irq   <= 1'b0;
          state <= SERVICE;
        end else if (!req[irq_id]) begin
          irq   <= 1'b0;
          state <= IDLE;
        end
        SERVICE: if (irq_eoi) state <= IDLE;
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed self-checking bench for ext_irq_ctrl.
module tb_ext_irq_ctrl;

  localparam int N = 31;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [N-1:0]  i_ext;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [N-1:0]  cfg_wdata;
  logic [N-1:0]  cfg_rdata;
  logic          irq;
  logic [4:0]    irq_id;
  logic          irq_ack;
  logic          irq_eoi;

  int n_chk  = 0;
  int n_pass = 0;

  ext_irq_ctrl dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_ext     (i_ext),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq       (irq),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .irq_eoi   (irq_eoi)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_neg(input int n);
    for (int k = 0; k < n; k++) @(negedge Clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    cfg_addr = a;
    #1;
    v = 32'(cfg_rdata);
  endtask

  task automatic wr(input logic [1:0] a, input logic [N-1:0] d);
    @(negedge Clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge Clk);
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic pulse_ack();
    @(negedge Clk); irq_ack = 1'b1;
    @(negedge Clk); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    @(negedge Clk); irq_eoi = 1'b1;
    @(negedge Clk); irq_eoi = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    Rst = 1'b1; i_ext = '0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    irq_ack = 1'b0; irq_eoi = 1'b0;

    // Reset held with all lines high
    #2 i_ext = '1;
    wait_neg(4);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    rd(2'd0, v); chk("rst_enable", v, 32'd0);
    rd(2'd1, v); chk("rst_mode", v, 32'd0);
    rd(2'd2, v); chk("rst_pending", v, 32'd0);
    rd(2'd3, v); chk("rst_status", v, 32'd0);
    i_ext = '0;
    @(negedge Clk); Rst = 1'b0;
    wait_neg(4);
    chk("post_rst_irq", 32'(irq), 32'd0);

    // Basic edge on line 2, latency check
    wr(2'd0, 31'h1FE);
    wr(2'd1, 31'h1FE);
    rd(2'd1, v); chk("mode_rb", v, 32'h1FE);
    @(negedge Clk); i_ext[2] = 1'b1;
    wait_neg(3);
    chk("edge_lat_early", 32'(irq), 32'd0);
    i_ext[2] = 1'b0;
    wait_neg(1);
    chk("edge_lat_irq", 32'(irq), 32'd1);
    chk("edge_lat_id", 32'(irq_id), 32'd2);
    rd(2'd3, v); chk("edge_status", v, 32'h4);
    pulse_ack();
    chk("edge_ack_irq", 32'(irq), 32'd0);
    rd(2'd2, v); chk("edge_ack_pend", v, 32'd0);
    rd(2'd3, v); chk("svc_status", v, 32'h4);
    pulse_eoi();
    rd(2'd3, v); chk("eoi_status", v, 32'd0);

    // Priority: 8 and 2 together, 2 first
    @(negedge Clk); i_ext[8] = 1'b1; i_ext[2] = 1'b1;
    wait_neg(5);
    chk("prio_irq", 32'(irq), 32'd1);
    chk("prio_id_a", 32'(irq_id), 32'd2);
    pulse_ack();
    rd(2'd2, v); chk("prio_pend", v, 32'h100);
    pulse_eoi();
    wait_neg(2);
    chk("prio_irq_b", 32'(irq), 32'd1);
    chk("prio_id_b", 32'(irq_id), 32'd8);
    pulse_ack();
    pulse_eoi();
    i_ext[8] = 1'b0; i_ext[2] = 1'b0;
    wait_neg(3);

    // Level mode on line 3, withdrawn while in REQ
    wr(2'd1, 31'h1F6);
    @(negedge Clk); i_ext[3] = 1'b1;
    wait_neg(5);
    chk("lvl_irq", 32'(irq), 32'd1);
    chk("lvl_id", 32'(irq_id), 32'd3);
    i_ext[3] = 1'b0;
    wait_neg(5);
    chk("lvl_drop_irq", 32'(irq), 32'd0);
    rd(2'd3, v); chk("lvl_drop_status", v, 32'd0);
    rd(2'd2, v); chk("lvl_drop_pend", v, 32'd0);

    // Narrow pulse between edges is lost
    @(posedge Clk); #1 i_ext[1] = 1'b1;
    #4 i_ext[1] = 1'b0;
    wait_neg(5);
    rd(2'd2, v); chk("narrow_lost", v, 32'd0);
    // Narrow pulse straddling an edge is caught
    @(negedge Clk); #3 i_ext[1] = 1'b1;
    #4 i_ext[1] = 1'b0;
    wait_neg(5);
    rd(2'd2, v); chk("narrow_caught", v, 32'h2);
    chk("narrow_id", 32'(irq_id), 32'd1);
    pulse_ack();
    pulse_eoi();

    // Write-clear racing a new edge on line 5
    @(negedge Clk); i_ext[5] = 1'b1;
    wait_neg(4);
    i_ext[5] = 1'b0;
    wait_neg(3);
    rd(2'd2, v); chk("race_pre", v, 32'h20);
    i_ext[5] = 1'b1;
    wait_neg(2);
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 31'h20;
    @(negedge Clk);
    cfg_we = 1'b0; cfg_wdata = '0;
    rd(2'd2, v); chk("race_keep", v, 32'h20);
    wr(2'd2, 31'h20);
    rd(2'd2, v); chk("w1c_clear", v, 32'd0);
    wait_neg(2);
    chk("w1c_withdraw", 32'(irq), 32'd0);
    i_ext[5] = 1'b0;
    wait_neg(3);

    // Reset in the middle of REQ
    @(negedge Clk); i_ext[6] = 1'b1;
    wait_neg(5);
    chk("mid_req_irq", 32'(irq), 32'd1);
    @(negedge Clk); #2 Rst = 1'b1;
    #1 chk("async_rst_irq", 32'(irq), 32'd0);
    rd(2'd0, v); chk("async_rst_en", v, 32'd0);
    rd(2'd1, v); chk("async_rst_mode", v, 32'd0);
    rd(2'd2, v); chk("async_rst_pend", v, 32'd0);
    i_ext = '0;
    wait_neg(2);
    Rst = 1'b0;
    wait_neg(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
